// File: rtl/morse_defs_pkg.sv
// Shared Morse definitions: letter codes, FSM encodings, symbol values and
// the (length, pattern) table for letters A..H, common to encoder and decoder.
package morse_defs_pkg;

    localparam int DEF_DOT_MAX    = 2;
    localparam int DEF_DASH_MAX   = 4;
    localparam int DEF_LETTER_GAP = 3;
    localparam int DEF_CNT_W      = 3;

    localparam int NUM_LETTERS = 8;
    localparam int MAX_SYMBOLS = 4;

    typedef enum logic [2:0] {
        LTR_A = 3'd0,
        LTR_B = 3'd1,
        LTR_C = 3'd2,
        LTR_D = 3'd3,
        LTR_E = 3'd4,
        LTR_F = 3'd5,
        LTR_G = 3'd6,
        LTR_H = 3'd7
    } letter_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MARK     = 2'd1,
        ST_GAP      = 2'd2,
        ST_ERR_WAIT = 2'd3
    } state_e;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    // Symbols are shifted in MSB-first, so the first symbol sent ends up
    // in the highest occupied bit and unused upper bits stay zero.
    typedef struct packed {
        logic [2:0] len;
        logic [3:0] bits;
    } pattern_t;

    function automatic pattern_t letter_pattern(input logic [2:0] code);
        pattern_t p;
        p = '0;
        case (code)
            LTR_A: p = '{len: 3'd2, bits: 4'b0001};
            LTR_B: p = '{len: 3'd4, bits: 4'b1000};
            LTR_C: p = '{len: 3'd4, bits: 4'b1010};
            LTR_D: p = '{len: 3'd3, bits: 4'b0100};
            LTR_E: p = '{len: 3'd1, bits: 4'b0000};
            LTR_F: p = '{len: 3'd4, bits: 4'b0010};
            LTR_G: p = '{len: 3'd3, bits: 4'b0110};
            LTR_H: p = '{len: 3'd4, bits: 4'b0000};
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/morse_pattern_lut.sv
// Combinational lookup from a collected symbol sequence (count + bits)
// to a letter code A..H; match is low for any unknown pattern.
module morse_pattern_lut
    import morse_defs_pkg::*;
(
    input  logic [2:0] sym_cnt,
    input  logic [3:0] sym_bits,
    output logic       match,
    output logic [2:0] letter
);

    pattern_t p;

    always_comb begin
        match  = 1'b0;
        letter = '0;
        p      = '0;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            p = letter_pattern(3'(i));
            if (!match && sym_cnt == p.len && sym_bits == p.bits) begin
                match  = 1'b1;
                letter = 3'(i);
            end
        end
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse line decoder: measures marks/spaces on tick strobes and emits a letter
// A..H with valid/error pulses. Define MORSE_DEC_SYNC_EN to add a 2-flop din synchronizer.
module morse_decoder
    import morse_defs_pkg::*;
#(
    parameter int DOT_MAX    = DEF_DOT_MAX,
    parameter int DASH_MAX   = DEF_DASH_MAX,
    parameter int LETTER_GAP = DEF_LETTER_GAP,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       din,
    output logic [2:0] letter,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    localparam logic [CNT_W-1:0] DOT_MAX_C  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] DASH_MAX_C = CNT_W'(DASH_MAX);
    localparam logic [CNT_W-1:0] GAP_C      = CNT_W'(LETTER_GAP);
    localparam logic [2:0]       SYM_MAX_C  = 3'(MAX_SYMBOLS);

    logic din_s;

`ifdef MORSE_DEC_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[0], din};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign din_s = sync_q[1];
`else
    assign din_s = din;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] mark_cnt_q, mark_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [2:0]       sym_cnt_q, sym_cnt_d;
    logic [3:0]       sym_q, sym_d;
    logic [2:0]       letter_q, letter_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             busy_q, busy_d;

    logic             lut_match;
    logic [2:0]       lut_letter;
    logic             mark_sym;
    logic [CNT_W-1:0] gap_inc;

    assign mark_sym = (mark_cnt_q <= DOT_MAX_C) ? SYM_DOT : SYM_DASH;
    assign gap_inc  = gap_cnt_q + CNT_W'(1);

    morse_pattern_lut u_lut (
        .sym_cnt  (sym_cnt_q),
        .sym_bits (sym_q),
        .match    (lut_match),
        .letter   (lut_letter)
    );

    // NOTE: every flop, counters and symbol register included, clears on the
    // asynchronous reset so a reset mid-letter leaves no partial state behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            mark_cnt_q <= '0;
            gap_cnt_q  <= '0;
            sym_cnt_q  <= '0;
            sym_q      <= '0;
            letter_q   <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            mark_cnt_q <= mark_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sym_cnt_q  <= sym_cnt_d;
            sym_q      <= sym_d;
            letter_q   <= letter_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments up front keep this block latch-free.
        state_d    = state_q;
        mark_cnt_d = mark_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        sym_cnt_d  = sym_cnt_q;
        sym_d      = sym_q;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (din_s) begin
                        state_d    = ST_MARK;
                        mark_cnt_d = CNT_W'(1);
                        sym_cnt_d  = '0;
                        sym_d      = '0;
                    end
                end
                ST_MARK: begin
                    if (din_s) begin
                        if (mark_cnt_q >= DASH_MAX_C) begin
                            state_d   = ST_ERR_WAIT;
                            gap_cnt_d = '0;
                        end else begin
                            mark_cnt_d = mark_cnt_q + CNT_W'(1);
                        end
                    end else if (sym_cnt_q >= SYM_MAX_C) begin
                        state_d   = ST_ERR_WAIT;
                        gap_cnt_d = '0;
                    end else begin
                        state_d   = ST_GAP;
                        sym_d     = {sym_q[2:0], mark_sym};
                        sym_cnt_d = sym_cnt_q + 3'd1;
                        gap_cnt_d = CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (din_s) begin
                        state_d    = ST_MARK;
                        mark_cnt_d = CNT_W'(1);
                    end else if (gap_inc >= GAP_C) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_inc;
                    end
                end
                ST_ERR_WAIT: begin
                    if (din_s) begin
                        gap_cnt_d = '0;
                    end else if (gap_inc >= GAP_C) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        valid_d  = 1'b0;
        error_d  = 1'b0;
        letter_d = letter_q;
        busy_d   = (state_d != ST_IDLE);
        if (tick) begin
            case (state_q)
                ST_MARK: begin
                    if (din_s && mark_cnt_q >= DASH_MAX_C)   error_d = 1'b1;
                    if (!din_s && sym_cnt_q >= SYM_MAX_C)    error_d = 1'b1;
                end
                ST_GAP: begin
                    if (!din_s && gap_inc >= GAP_C) begin
                        if (lut_match) begin
                            valid_d  = 1'b1;
                            letter_d = lut_letter;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign letter = letter_q;
    assign valid  = valid_q;
    assign error  = error_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed testbench for morse_decoder: tick every 4 clk, marks/spaces built
// from tick samples, expected letters and pulses hand-derived from the letter table.
module tb_morse_decoder;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       tick  = 1'b0;
    logic       din   = 1'b0;
    logic [2:0] letter;
    logic       valid;
    logic       error;
    logic       busy;

    int checks        = 0;
    int failures      = 0;
    int valid_pulses  = 0;
    int error_pulses  = 0;

    morse_decoder dut (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .din    (din),
        .letter (letter),
        .valid  (valid),
        .error  (error),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid === 1'b1) valid_pulses++;
        if (error === 1'b1) error_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Entered and left #1 after a posedge; the tick edge is the last posedge.
    task automatic tick_bit(input logic d);
        din = d;
        repeat (3) @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
    endtask

    task automatic space(input int n);
        for (int i = 0; i < n; i++) tick_bit(1'b0);
    endtask

    task automatic mark(input int n);
        for (int i = 0; i < n; i++) tick_bit(1'b1);
    endtask

    // Sends n symbols MSB-first with 1-tick intra-letter gaps, no letter gap.
    task automatic send_symbols(input int n, input logic [3:0] bits,
                                input int dot_len, input int dash_len);
        for (int i = n - 1; i >= 0; i--) begin
            mark(bits[i] ? dash_len : dot_len);
            if (i != 0) space(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({letter, valid, error, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got letter=%0d valid=%b error=%b busy=%b, want all 0",
                     letter, valid, error, busy);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_loopback_a();
        int v0, e0;
        v0 = valid_pulses;
        e0 = error_pulses;
        mark(1); space(1); mark(3);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL a_busy: got %b want 1", busy);
        end
        space(2);
        tick_bit(1'b0);
        checks++;
        if (valid !== 1'b1 || letter !== 3'd0) begin
            failures++;
            $display("FAIL a_valid: got valid=%b letter=%0d want valid=1 letter=0", valid, letter);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL a_pulse_width: got valid=%b one clk later want 0", valid);
        end
        checks++;
        if (valid_pulses - v0 !== 1 || error_pulses - e0 !== 0) begin
            failures++;
            $display("FAIL a_counts: got valid_cycles=%0d error_cycles=%0d want 1 and 0",
                     valid_pulses - v0, error_pulses - e0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL a_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_h();
        int v0;
        for (int rep = 1; rep <= 2; rep++) begin
            v0 = valid_pulses;
            send_symbols(4, 4'b0000, rep, 3);
            space(2);
            tick_bit(1'b0);
            checks++;
            if (valid !== 1'b1 || letter !== 3'd7 || error !== 1'b0) begin
                failures++;
                $display("FAIL h_dot%0d: got valid=%b letter=%0d error=%b want valid=1 letter=7 error=0",
                         rep, valid, letter, error);
            end
            @(posedge clk);
            #1;
            checks++;
            if (valid_pulses - v0 !== 1) begin
                failures++;
                $display("FAIL h_dot%0d_count: got %0d valid cycles want 1", rep, valid_pulses - v0);
            end
        end
    endtask

    task automatic test_long_mark();
        int v0, e0;
        v0 = valid_pulses;
        e0 = error_pulses;
        mark(4);
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL long_early: got error=%b after 4 high ticks want 0", error);
        end
        tick_bit(1'b1);
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL long_error: got error=%b after 5th high tick want 1", error);
        end
        space(3);
        checks++;
        if (busy !== 1'b0 || valid_pulses - v0 !== 0 || error_pulses - e0 !== 1) begin
            failures++;
            $display("FAIL long_recover: got busy=%b valid_cycles=%0d error_cycles=%0d want 0 0 1",
                     busy, valid_pulses - v0, error_pulses - e0);
        end
    endtask

    task automatic test_five_dots();
        int v0;
        v0 = valid_pulses;
        send_symbols(4, 4'b0000, 1, 3);
        space(1);
        mark(1);
        tick_bit(1'b0);
        checks++;
        if (error !== 1'b1 || valid !== 1'b0) begin
            failures++;
            $display("FAIL five_error: got error=%b valid=%b want error=1 valid=0", error, valid);
        end
        space(3);
        checks++;
        if (busy !== 1'b0 || letter !== 3'd7 || valid_pulses - v0 !== 0) begin
            failures++;
            $display("FAIL five_hold: got busy=%b letter=%0d valid_cycles=%0d want 0 7 0",
                     busy, letter, valid_pulses - v0);
        end
    endtask

    task automatic test_unmatched();
        int v0, e0;
        v0 = valid_pulses;
        e0 = error_pulses;
        send_symbols(4, 4'b1111, 1, 3);
        space(2);
        tick_bit(1'b0);
        checks++;
        if (error !== 1'b1 || valid !== 1'b0) begin
            failures++;
            $display("FAIL unmatched_error: got error=%b valid=%b want error=1 valid=0", error, valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (error_pulses - e0 !== 1 || valid_pulses - v0 !== 0 || letter !== 3'd7) begin
            failures++;
            $display("FAIL unmatched_hold: got error_cycles=%0d valid_cycles=%0d letter=%0d want 1 0 7",
                     error_pulses - e0, valid_pulses - v0, letter);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = valid_pulses;
        send_symbols(4, 4'b1010, 1, 3);
        space(2);
        tick_bit(1'b0);
        checks++;
        if (valid !== 1'b1 || letter !== 3'd2) begin
            failures++;
            $display("FAIL b2b_c: got valid=%b letter=%0d want valid=1 letter=2", valid, letter);
        end
        send_symbols(1, 4'b0000, 1, 3);
        space(2);
        tick_bit(1'b0);
        checks++;
        if (valid !== 1'b1 || letter !== 3'd4) begin
            failures++;
            $display("FAIL b2b_e: got valid=%b letter=%0d want valid=1 letter=4", valid, letter);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_pulses - v0 !== 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d valid cycles want 2", valid_pulses - v0);
        end
    endtask

    task automatic test_reset_mid_letter();
        int v0, e0;
        mark(3);
        space(1);
        tick_bit(1'b1);
        v0 = valid_pulses;
        e0 = error_pulses;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({letter, valid, error, busy} !== 6'b0) begin
            failures++;
            $display("FAIL midreset_outputs: got letter=%0d valid=%b error=%b busy=%b want all 0",
                     letter, valid, error, busy);
        end
        din = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        send_symbols(3, 4'b0100, 1, 3);
        space(2);
        tick_bit(1'b0);
        checks++;
        if (valid !== 1'b1 || letter !== 3'd3 || error !== 1'b0) begin
            failures++;
            $display("FAIL midreset_d: got valid=%b letter=%0d error=%b want valid=1 letter=3 error=0",
                     valid, letter, error);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_pulses - v0 !== 1 || error_pulses - e0 !== 0) begin
            failures++;
            $display("FAIL midreset_counts: got valid_cycles=%0d error_cycles=%0d want 1 0",
                     valid_pulses - v0, error_pulses - e0);
        end
    endtask

    initial begin
        test_reset();
        test_loopback_a();
        test_h();
        test_long_mark();
        test_five_dots();
        test_unmatched();
        test_back_to_back();
        test_reset_mid_letter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
